// File: rtl/ahb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ahb_sdram_arbiter
// Brief    : Two-master AHB-Lite arbiter sharing one SDRAM controller port.
//            Master address phases are captured into per-master pending
//            buffers and replayed to the SDRAM port one at a time under
//            round-robin priority; losing masters are stalled via HREADYOUT.
// Revision : 1.0  initial release
// ============================================================================
module ahb_sdram_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    // master 0 slave port
    input  logic              m0_HSEL,
    input  logic [ADDR_W-1:0] m0_HADDR,
    input  logic              m0_HWRITE,
    input  logic [1:0]        m0_HTRANS,
    input  logic [2:0]        m0_HSIZE,
    input  logic [DATA_W-1:0] m0_HWDATA,
    output logic [DATA_W-1:0] m0_HRDATA,
    output logic              m0_HREADYOUT,
    output logic              m0_HRESP,
    // master 1 slave port
    input  logic              m1_HSEL,
    input  logic [ADDR_W-1:0] m1_HADDR,
    input  logic              m1_HWRITE,
    input  logic [1:0]        m1_HTRANS,
    input  logic [2:0]        m1_HSIZE,
    input  logic [DATA_W-1:0] m1_HWDATA,
    output logic [DATA_W-1:0] m1_HRDATA,
    output logic              m1_HREADYOUT,
    output logic              m1_HRESP,
    // SDRAM controller port
    output logic [ADDR_W-1:0] s_HADDR,
    output logic              s_HWRITE,
    output logic [1:0]        s_HTRANS,
    output logic [2:0]        s_HSIZE,
    output logic [DATA_W-1:0] s_HWDATA,
    input  logic [DATA_W-1:0] s_HRDATA,
    input  logic              s_HREADY,
    input  logic              s_HRESP,
    // current owner of the SDRAM port
    output logic [1:0]        grant
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ADDR = 2'd1;
    localparam logic [1:0] c_ST_DATA = 2'd2;

    localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic              r_owner;        // 0 = m0, 1 = m1
    logic              w_owner_next;
    logic              r_last_grant;   // 0 = m0, 1 = m1
    logic              w_last_next;
    logic [1:0]        r_pend;
    logic [1:0]        w_pend_next;
    logic [1:0]        w_cap;
    logic [1:0]        w_hready;
    logic              w_pick;
    logic              w_in_addr;
    logic              w_in_data;
    logic              w_active;
    logic              w_done;
    logic              w_own0;
    logic              w_own1;

    logic [ADDR_W-1:0] r_addr0;
    logic [ADDR_W-1:0] r_addr1;
    logic              r_write0;
    logic              r_write1;
    logic [2:0]        r_size0;
    logic [2:0]        r_size1;

    // HTRANS[0] only separates SEQ from NONSEQ and IDLE from BUSY; both pairs
    // are treated alike, so the low bit carries no information here.
    logic              w_unused;
    assign w_unused = &{1'b0, m0_HTRANS[0], m1_HTRANS[0]};

    assign w_in_addr = (r_state == c_ST_ADDR);
    assign w_in_data = (r_state == c_ST_DATA);
    assign w_active  = w_in_addr | w_in_data;
    assign w_own0    = w_active & ~r_owner;
    assign w_own1    = w_active &  r_owner;
    assign w_done    = w_in_data & s_HREADY;

    // Per-master ready: owner follows the SDRAM in its data phase, is held in
    // the address phase; everyone else is ready unless a request is parked.
    always_comb begin
        w_hready[0] = ~r_pend[0];
        w_hready[1] = ~r_pend[1];
        if (w_own0 && w_in_addr) begin
            w_hready[0] = 1'b0;
        end else if (w_own0 && w_in_data) begin
            w_hready[0] = s_HREADY;
        end
        if (w_own1 && w_in_addr) begin
            w_hready[1] = 1'b0;
        end else if (w_own1 && w_in_data) begin
            w_hready[1] = s_HREADY;
        end
    end

    assign w_cap[0] = m0_HSEL & m0_HTRANS[1] & w_hready[0];
    assign w_cap[1] = m1_HSEL & m1_HTRANS[1] & w_hready[1];

    // Pending view after this edge: a completing owner keeps its flag only if
    // it recaptured in the same cycle.
    always_comb begin
        w_pend_next = r_pend | w_cap;
        if (w_done && w_own0) begin
            w_pend_next[0] = w_cap[0];
        end
        if (w_done && w_own1) begin
            w_pend_next[1] = w_cap[1];
        end
    end

    assign w_last_next = w_done ? r_owner : r_last_grant;
    // Round robin: on a tie the master not granted last wins.
    assign w_pick      = (&w_pend_next) ? ~w_last_next : w_pend_next[1];

    // Next-state and owner selection.
    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        case (r_state)
            c_ST_IDLE: begin
                if (|w_pend_next) begin
                    w_state_next = c_ST_ADDR;
                    w_owner_next = w_pick;
                end
            end
            c_ST_ADDR: begin
                if (s_HREADY) begin
                    w_state_next = c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                if (s_HREADY) begin
                    if (|w_pend_next) begin
                        w_state_next = c_ST_ADDR;
                        w_owner_next = w_pick;
                    end else begin
                        w_state_next = c_ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // FSM, ownership, round-robin history and pending flags.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state      <= c_ST_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_pend       <= 2'b00;
        end else begin
            r_state      <= w_state_next;
            r_owner      <= w_owner_next;
            r_last_grant <= w_last_next;
            r_pend       <= w_pend_next;
        end
    end

    // Address-phase capture buffers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr0  <= '0;
            r_write0 <= 1'b0;
            r_size0  <= 3'd0;
            r_addr1  <= '0;
            r_write1 <= 1'b0;
            r_size1  <= 3'd0;
        end else begin
            if (w_cap[0]) begin
                r_addr0  <= m0_HADDR;
                r_write0 <= m0_HWRITE;
                r_size0  <= m0_HSIZE;
            end
            if (w_cap[1]) begin
                r_addr1  <= m1_HADDR;
                r_write1 <= m1_HWRITE;
                r_size1  <= m1_HSIZE;
            end
        end
    end

    // SDRAM-side outputs; zero whenever the port is not owned.
    always_comb begin
        s_HTRANS = w_in_addr ? c_HTRANS_NONSEQ : c_HTRANS_IDLE;
        s_HADDR  = '0;
        s_HWRITE = 1'b0;
        s_HSIZE  = 3'd0;
        s_HWDATA = '0;
        grant    = 2'b00;
        if (w_active) begin
            s_HADDR  = r_owner ? r_addr1  : r_addr0;
            s_HWRITE = r_owner ? r_write1 : r_write0;
            s_HSIZE  = r_owner ? r_size1  : r_size0;
            grant    = r_owner ? 2'b10 : 2'b01;
        end
        if (w_in_data) begin
            s_HWDATA = r_owner ? m1_HWDATA : m0_HWDATA;
        end
    end

    // Master-side responses; only the data-phase owner sees SDRAM data/resp.
    always_comb begin
        m0_HREADYOUT = w_hready[0];
        m1_HREADYOUT = w_hready[1];
        m0_HRESP     = 1'b0;
        m1_HRESP     = 1'b0;
        m0_HRDATA    = '0;
        m1_HRDATA    = '0;
        if (w_own0 && w_in_data) begin
            m0_HRESP  = s_HRESP;
            m0_HRDATA = s_HRDATA;
        end
        if (w_own1 && w_in_data) begin
            m1_HRESP  = s_HRESP;
            m1_HRDATA = s_HRDATA;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_sdram_arbiter
// Brief    : Directed self-checking bench for ahb_sdram_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_ahb_sdram_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              HCLK;
    logic              HRESETn;
    logic              m0_HSEL,   m1_HSEL;
    logic [ADDR_W-1:0] m0_HADDR,  m1_HADDR;
    logic              m0_HWRITE, m1_HWRITE;
    logic [1:0]        m0_HTRANS, m1_HTRANS;
    logic [2:0]        m0_HSIZE,  m1_HSIZE;
    logic [DATA_W-1:0] m0_HWDATA, m1_HWDATA;
    logic [DATA_W-1:0] m0_HRDATA, m1_HRDATA;
    logic              m0_HREADYOUT, m1_HREADYOUT;
    logic              m0_HRESP,  m1_HRESP;
    logic [ADDR_W-1:0] s_HADDR;
    logic              s_HWRITE;
    logic [1:0]        s_HTRANS;
    logic [2:0]        s_HSIZE;
    logic [DATA_W-1:0] s_HWDATA;
    logic [DATA_W-1:0] s_HRDATA;
    logic              s_HREADY;
    logic              s_HRESP;
    logic [1:0]        grant;

    int n_vec = 0;
    int n_err = 0;

    ahb_sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .m0_HSEL(m0_HSEL), .m0_HADDR(m0_HADDR), .m0_HWRITE(m0_HWRITE),
        .m0_HTRANS(m0_HTRANS), .m0_HSIZE(m0_HSIZE), .m0_HWDATA(m0_HWDATA),
        .m0_HRDATA(m0_HRDATA), .m0_HREADYOUT(m0_HREADYOUT), .m0_HRESP(m0_HRESP),
        .m1_HSEL(m1_HSEL), .m1_HADDR(m1_HADDR), .m1_HWRITE(m1_HWRITE),
        .m1_HTRANS(m1_HTRANS), .m1_HSIZE(m1_HSIZE), .m1_HWDATA(m1_HWDATA),
        .m1_HRDATA(m1_HRDATA), .m1_HREADYOUT(m1_HREADYOUT), .m1_HRESP(m1_HRESP),
        .s_HADDR(s_HADDR), .s_HWRITE(s_HWRITE), .s_HTRANS(s_HTRANS),
        .s_HSIZE(s_HSIZE), .s_HWDATA(s_HWDATA), .s_HRDATA(s_HRDATA),
        .s_HREADY(s_HREADY), .s_HRESP(s_HRESP), .grant(grant)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
    task automatic cyc;
        @(posedge HCLK);
        #1;
    endtask

    task automatic settle;
        @(negedge HCLK);
    endtask

    task automatic reset_pulse;
        HRESETn = 1'b0;
        cyc;
        cyc;
        HRESETn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        HRESETn = 1'b0;
        m0_HSEL = 0; m0_HADDR = 0; m0_HWRITE = 0; m0_HTRANS = 0; m0_HSIZE = 0; m0_HWDATA = 0;
        m1_HSEL = 0; m1_HADDR = 0; m1_HWRITE = 0; m1_HTRANS = 0; m1_HSIZE = 0; m1_HWDATA = 0;
        s_HRDATA = 0; s_HREADY = 1'b1; s_HRESP = 1'b0;

        // ---------------- reset state
        cyc; cyc; settle;
        chk("rst_m0_ready", m0_HREADYOUT, 1);
        chk("rst_m1_ready", m1_HREADYOUT, 1);
        chk("rst_grant",    grant, 0);
        chk("rst_htrans",   s_HTRANS, 0);
        chk("rst_haddr",    s_HADDR, 0);
        chk("rst_m0_resp",  m0_HRESP, 0);
        cyc;
        HRESETn = 1'b1;

        // ---------------- m0 read 0x100 with one SDRAM wait state
        m0_HSEL = 1; m0_HTRANS = 2'b10; m0_HADDR = 32'h100; m0_HWRITE = 0; m0_HSIZE = 3'd2;
        settle;
        chk("t1_n_ready", m0_HREADYOUT, 1);
        chk("t1_n_htrans", s_HTRANS, 0);
        cyc; m0_HSEL = 0; m0_HTRANS = 0; settle;                       // N+1
        chk("t1_n1_htrans", s_HTRANS, 2'b10);
        chk("t1_n1_haddr",  s_HADDR, 32'h100);
        chk("t1_n1_hsize",  s_HSIZE, 3'd2);
        chk("t1_n1_grant",  grant, 2'b01);
        chk("t1_n1_ready",  m0_HREADYOUT, 0);
        cyc; s_HREADY = 0; settle;                                     // N+2 wait
        chk("t1_n2_ready",  m0_HREADYOUT, 0);
        chk("t1_n2_htrans", s_HTRANS, 0);
        cyc; s_HREADY = 1; s_HRDATA = 32'hDEADBEEF; settle;            // N+3 done
        chk("t1_n3_ready",  m0_HREADYOUT, 1);
        chk("t1_n3_rdata",  m0_HRDATA, 32'hDEADBEEF);
        chk("t1_n3_m1data", m1_HRDATA, 0);
        cyc; s_HRDATA = 0; settle;
        chk("t1_idle_grant", grant, 0);

        // ---------------- simultaneous writes after reset: m0 first
        reset_pulse;
        m0_HSEL = 1; m0_HTRANS = 2'b10; m0_HADDR = 32'hA0; m0_HWRITE = 1;
        m1_HSEL = 1; m1_HTRANS = 2'b10; m1_HADDR = 32'hB0; m1_HWRITE = 1;
        settle;
        chk("t2_m0_ready0", m0_HREADYOUT, 1);
        chk("t2_m1_ready0", m1_HREADYOUT, 1);
        cyc;
        m0_HSEL = 0; m0_HTRANS = 0; m0_HWDATA = 32'h1111_0000;
        m1_HSEL = 0; m1_HTRANS = 0; m1_HWDATA = 32'h2222_0000;
        settle;
        chk("t2_a_grant",  grant, 2'b01);
        chk("t2_a_haddr",  s_HADDR, 32'hA0);
        chk("t2_a_hwrite", s_HWRITE, 1);
        chk("t2_a_m1rdy",  m1_HREADYOUT, 0);
        cyc; settle;
        chk("t2_d_hwdata", s_HWDATA, 32'h1111_0000);
        chk("t2_d_m0rdy",  m0_HREADYOUT, 1);
        chk("t2_d_m1rdy",  m1_HREADYOUT, 0);
        cyc; settle;
        chk("t2_b_grant",  grant, 2'b10);
        chk("t2_b_haddr",  s_HADDR, 32'hB0);
        chk("t2_b_m1rdy",  m1_HREADYOUT, 0);
        cyc; settle;
        chk("t2_e_hwdata", s_HWDATA, 32'h2222_0000);
        chk("t2_e_m1rdy",  m1_HREADYOUT, 1);
        cyc; settle;
        chk("t2_idle_grant", grant, 0);

        // ---------------- both masters streaming: grant alternates
        cyc;
        m0_HSEL = 1; m0_HTRANS = 2'b10; m0_HADDR = 32'h200; m0_HWRITE = 0;
        m1_HSEL = 1; m1_HTRANS = 2'b11; m1_HADDR = 32'h300; m1_HWRITE = 0;
        settle;
        cyc; settle;
        chk("t3_g1", grant, 2'b01);
        chk("t3_a1", s_HADDR, 32'h200);
        cyc; settle;
        cyc; settle;
        chk("t3_g2", grant, 2'b10);
        chk("t3_a2", s_HADDR, 32'h300);
        cyc; settle;
        cyc;
        m0_HSEL = 0; m0_HTRANS = 0; m1_HSEL = 0; m1_HTRANS = 0;
        settle;
        chk("t3_g3", grant, 2'b01);
        k = 0;
        while (grant != 2'b00 && k < 10) begin
            cyc; settle;
            k++;
        end
        chk("t3_drain", grant, 0);

        // ---------------- ERROR on m1 write, queued m0 read completes OKAY
        cyc;
        m1_HSEL = 1; m1_HTRANS = 2'b10; m1_HADDR = 32'hC0; m1_HWRITE = 1;
        settle;
        cyc;
        m1_HSEL = 0; m1_HTRANS = 0; m1_HWDATA = 32'h33;
        m0_HSEL = 1; m0_HTRANS = 2'b10; m0_HADDR = 32'hD0; m0_HWRITE = 0;
        settle;
        chk("t4_grant_m1", grant, 2'b10);
        cyc;
        m0_HSEL = 0; m0_HTRANS = 0; s_HREADY = 0; s_HRESP = 1;
        settle;
        chk("t4_e1_resp",  m1_HRESP, 1);
        chk("t4_e1_ready", m1_HREADYOUT, 0);
        chk("t4_e1_m0rdy", m0_HREADYOUT, 0);
        chk("t4_e1_wdata", s_HWDATA, 32'h33);
        cyc; s_HREADY = 1; settle;
        chk("t4_e2_resp",  m1_HRESP, 1);
        chk("t4_e2_ready", m1_HREADYOUT, 1);
        cyc; s_HRESP = 0; settle;
        chk("t4_m0_grant", grant, 2'b01);
        chk("t4_m0_haddr", s_HADDR, 32'hD0);
        chk("t4_m1_resp0", m1_HRESP, 0);
        cyc; s_HRDATA = 32'h55AA; settle;
        chk("t4_m0_ready", m0_HREADYOUT, 1);
        chk("t4_m0_resp",  m0_HRESP, 0);
        chk("t4_m0_rdata", m0_HRDATA, 32'h55AA);
        cyc; s_HRDATA = 0; settle;

        // ---------------- reset during DATA of an m0 read
        cyc;
        m0_HSEL = 1; m0_HTRANS = 2'b10; m0_HADDR = 32'h1E0; m0_HWRITE = 0;
        settle;
        cyc; m0_HSEL = 0; m0_HTRANS = 0; settle;
        chk("t5_addr_grant", grant, 2'b01);
        cyc; s_HREADY = 0; settle;
        chk("t5_data_grant", grant, 2'b01);
        HRESETn = 1'b0;
        #1;
        chk("t5_rst_htrans", s_HTRANS, 0);
        chk("t5_rst_grant",  grant, 0);
        chk("t5_rst_m0rdy",  m0_HREADYOUT, 1);
        chk("t5_rst_m1rdy",  m1_HREADYOUT, 1);
        cyc; s_HREADY = 1;
        cyc; HRESETn = 1'b1;
        m1_HSEL = 1; m1_HTRANS = 2'b10; m1_HADDR = 32'hF0; m1_HWRITE = 0;
        settle;
        chk("t5_m1_ready0", m1_HREADYOUT, 1);
        cyc; m1_HSEL = 0; m1_HTRANS = 0; settle;
        chk("t5_m1_grant", grant, 2'b10);
        chk("t5_m1_haddr", s_HADDR, 32'hF0);
        cyc; s_HRDATA = 32'h77; settle;
        chk("t5_m1_rdata", m1_HRDATA, 32'h77);
        chk("t5_m1_ready", m1_HREADYOUT, 1);
        cyc; s_HRDATA = 0; settle;

        // ---------------- BUSY and unselected requests are ignored
        cyc;
        m0_HSEL = 1; m0_HTRANS = 2'b01; m0_HADDR = 32'h400;
        settle;
        chk("t6_busy_ready", m0_HREADYOUT, 1);
        cyc; settle;
        chk("t6_busy_htrans", s_HTRANS, 0);
        chk("t6_busy_grant",  grant, 0);
        chk("t6_busy_ready2", m0_HREADYOUT, 1);
        m0_HSEL = 0; m0_HTRANS = 2'b10;
        cyc; settle;
        chk("t6_nosel_htrans", s_HTRANS, 0);
        chk("t6_nosel_grant",  grant, 0);
        chk("t6_nosel_ready",  m0_HREADYOUT, 1);
        m0_HTRANS = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
